// File: rtl/multicycle_control_fsm.sv
// Main control unit for a multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives datapath enables, mux selects and ALUOp.
module multicycle_control_fsm #(
    parameter int OPC_W = 6,
    parameter int AOP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    input  logic             mem_ready,
    output logic [AOP_W-1:0] ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic [1:0]       PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             instr_done,
    output logic             illegal_op
);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'('h00);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'('h02);
    localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'('h03);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'('h04);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'('h05);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'('h08);
    localparam logic [OPC_W-1:0] OP_ANDI  = OPC_W'('h0C);
    localparam logic [OPC_W-1:0] OP_ORI   = OPC_W'('h0D);
    localparam logic [OPC_W-1:0] OP_LUI   = OPC_W'('h0F);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'('h23);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'('h2B);
    localparam logic [OPC_W-1:0] FN_JR    = OPC_W'('h08);

    localparam logic [AOP_W-1:0] AOP_R    = AOP_W'(3'b111);
    localparam logic [AOP_W-1:0] AOP_ADD  = AOP_W'(3'b011);
    localparam logic [AOP_W-1:0] AOP_ORI  = AOP_W'(3'b001);
    localparam logic [AOP_W-1:0] AOP_ANDI = AOP_W'(3'b000);
    localparam logic [AOP_W-1:0] AOP_LUI  = AOP_W'(3'b101);
    localparam logic [AOP_W-1:0] AOP_SUB  = AOP_W'(3'b100);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_MEM_ADDR,
        S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_JAL, S_JR
    } state_t;

    typedef struct packed {
        logic [AOP_W-1:0] aluop;
        logic             alusrca;
        logic [1:0]       alusrcb;
        logic             pcwrite;
        logic             pcwritecond;
        logic             branchne;
        logic [1:0]       pcsource;
        logic             iord;
        logic             memread;
        logic             memwrite;
        logic             irwrite;
        logic             regwrite;
        logic [1:0]       regdst;
        logic [1:0]       memtoreg;
        logic             instr_done;
    } ctl_t;

    state_t           state;
    state_t           state_nx;
    ctl_t             ctl_q;
    ctl_t             ctl_o;
    logic [OPC_W-1:0] op_q;
    logic             hs_ok;

    function automatic logic legal_op(input logic [OPC_W-1:0] op);
        return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                          OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
    endfunction

    function automatic logic [AOP_W-1:0] imm_aluop(input logic [OPC_W-1:0] op);
        logic [AOP_W-1:0] a;
        case (op)
            OP_ANDI: a = AOP_ANDI;
            OP_ORI:  a = AOP_ORI;
            OP_LUI:  a = AOP_LUI;
            default: a = AOP_ADD;
        endcase
        return a;
    endfunction

    function automatic state_t step(input state_t s, input logic [OPC_W-1:0] op, fn, saved,
                                    input logic rdy);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:     n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                          n = (fn == FN_JR) ? S_JR : S_R_EXEC;
                    OP_LW, OP_SW:                      n = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    n = S_BRANCH;
                    OP_J:                              n = S_JUMP;
                    OP_JAL:                            n = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  n = S_I_EXEC;
                    default:                           n = S_FETCH;
                endcase
            end
            S_R_EXEC:    n = S_R_WB;
            S_I_EXEC:    n = S_I_WB;
            S_MEM_ADDR:  n = (saved == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  n = rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: n = rdy ? S_FETCH : S_MEM_WRITE;
            default:     n = S_FETCH;
        endcase
        return n;
    endfunction

    // Control word for a state; op matters only when entering I_EXEC or BRANCH from DECODE.
    function automatic ctl_t moore_outs(input state_t s, input logic [OPC_W-1:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'd1;
                c.aluop   = AOP_ADD;
                c.pcwrite = 1'b1;
                c.irwrite = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb = 2'd3;
                c.aluop   = AOP_ADD;
            end
            S_R_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = AOP_R;
            end
            S_R_WB: begin
                c.regwrite   = 1'b1;
                c.regdst     = 2'd1;
                c.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
                c.aluop   = imm_aluop(op);
            end
            S_I_WB: begin
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
                c.aluop   = AOP_ADD;
            end
            S_MEM_READ: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEM_WB: begin
                c.regwrite   = 1'b1;
                c.memtoreg   = 2'd1;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.memwrite   = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = AOP_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'd1;
                c.branchne    = op[0];
                c.instr_done  = 1'b1;
            end
            S_JUMP: begin
                c.pcwrite    = 1'b1;
                c.pcsource   = 2'd2;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.regwrite   = 1'b1;
                c.regdst     = 2'd2;
                c.memtoreg   = 2'd2;
                c.pcwrite    = 1'b1;
                c.pcsource   = 2'd2;
                c.instr_done = 1'b1;
            end
            S_JR: begin
                c.pcwrite    = 1'b1;
                c.pcsource   = 2'd3;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign state_nx = step(state, opcode, funct, op_q, mem_ready);

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ctl_q <= moore_outs(S_FETCH, opcode);
        end else begin
            state <= state_nx;
            ctl_q <= moore_outs(state_nx, opcode);
        end
        if (state == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // Handshake-terminated states commit only on the cycle memory completes.
    assign hs_ok = (state == S_FETCH || state == S_MEM_WRITE) ? mem_ready : 1'b1;
    assign ctl_o = reset ? '0 : ctl_q;

    assign ALUOp       = ctl_o.aluop;
    assign ALUSrcA     = ctl_o.alusrca;
    assign ALUSrcB     = ctl_o.alusrcb;
    assign PCWrite     = ctl_o.pcwrite & hs_ok;
    assign PCWriteCond = ctl_o.pcwritecond;
    assign BranchNE    = ctl_o.branchne;
    assign PCSource    = ctl_o.pcsource;
    assign IorD        = ctl_o.iord;
    assign MemRead     = ctl_o.memread;
    assign MemWrite    = ctl_o.memwrite;
    assign IRWrite     = ctl_o.irwrite & hs_ok;
    assign RegWrite    = ctl_o.regwrite;
    assign RegDst      = ctl_o.regdst;
    assign MemtoReg    = ctl_o.memtoreg;
    assign instr_done  = ctl_o.instr_done & hs_ok;
    assign illegal_op  = ~reset & (state == S_DECODE) & ~legal_op(opcode);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction cycle model built from the
// instruction-level step list, checked every cycle, plus literal latencies.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic [2:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNE;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       instr_done;
    logic       illegal_op;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPC_W(6), .AOP_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic [2:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       pcw;
        logic       pcwc;
        logic       bne;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       done;
        logic       ill;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [5:0] op;
        logic [5:0] fn;
        outs_t      exp;
        logic       start;
        int         lat;
    } cyc_t;

    cyc_t       q[$];
    cyc_t       cur;
    logic       cur_valid = 1'b0;
    outs_t      dut_o;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc_in = 0;
    int         lat_exp = 0;
    int         cyc_no = 0;
    logic [5:0] m_op;
    logic [5:0] m_fn;
    logic       m_first;
    int         m_lat;

    assign dut_o = {ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond, BranchNE, PCSource,
                    IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                    instr_done, illegal_op};

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                          6'h0F, 6'h23, 6'h2B};
    endfunction

    function automatic outs_t fetch_word();
        outs_t o;
        o = '0;
        o.mrd = 1'b1;
        o.srcb = 2'd1;
        o.aluop = 3'b011;
        return o;
    endfunction

    task automatic push_cyc(input logic rst, input logic mr, input outs_t o);
        cyc_t c;
        c.rst = rst;
        c.mr = mr;
        c.op = m_op;
        c.fn = m_fn;
        c.exp = o;
        c.start = m_first;
        c.lat = m_lat;
        m_first = 1'b0;
        q.push_back(c);
    endtask

    // Model: one instruction as its list of cycles; wf/wm are mem_ready wait cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input int lat);
        outs_t o;
        m_op = op;
        m_fn = fn;
        m_first = 1'b1;
        m_lat = lat;
        for (int i = 0; i < wf; i++) push_cyc(1'b0, 1'b0, fetch_word());
        o = fetch_word(); o.irw = 1'b1; o.pcw = 1'b1;
        push_cyc(1'b0, 1'b1, o);
        o = '0; o.srcb = 2'd3; o.aluop = 3'b011; o.ill = !is_legal(op);
        push_cyc(1'b0, 1'b1, o);
        if (op == 6'h00 && fn == 6'h08) begin
            o = '0; o.pcw = 1'b1; o.pcsrc = 2'd3; o.done = 1'b1;
            push_cyc(1'b0, 1'b1, o);
        end else begin
            case (op)
                6'h00: begin
                    o = '0; o.srca = 1'b1; o.aluop = 3'b111;
                    push_cyc(1'b0, 1'b1, o);
                    o = '0; o.rw = 1'b1; o.rdst = 2'd1; o.done = 1'b1;
                    push_cyc(1'b0, 1'b1, o);
                end
                6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                    o = '0; o.srca = 1'b1; o.srcb = 2'd2;
                    o.aluop = (op == 6'h08) ? 3'b011 : (op == 6'h0C) ? 3'b000 :
                              (op == 6'h0D) ? 3'b001 : 3'b101;
                    push_cyc(1'b0, 1'b1, o);
                    o = '0; o.rw = 1'b1; o.done = 1'b1;
                    push_cyc(1'b0, 1'b1, o);
                end
                6'h23, 6'h2B: begin
                    o = '0; o.srca = 1'b1; o.srcb = 2'd2; o.aluop = 3'b011;
                    push_cyc(1'b0, 1'b1, o);
                    o = '0; o.iord = 1'b1; o.mrd = (op == 6'h23); o.mwr = (op == 6'h2B);
                    for (int i = 0; i < wm; i++) push_cyc(1'b0, 1'b0, o);
                    o.done = (op == 6'h2B);
                    push_cyc(1'b0, 1'b1, o);
                    if (op == 6'h23) begin
                        o = '0; o.rw = 1'b1; o.m2r = 2'd1; o.done = 1'b1;
                        push_cyc(1'b0, 1'b1, o);
                    end
                end
                6'h04, 6'h05: begin
                    o = '0; o.srca = 1'b1; o.aluop = 3'b100; o.pcwc = 1'b1;
                    o.pcsrc = 2'd1; o.bne = op[0]; o.done = 1'b1;
                    push_cyc(1'b0, 1'b1, o);
                end
                6'h02: begin
                    o = '0; o.pcw = 1'b1; o.pcsrc = 2'd2; o.done = 1'b1;
                    push_cyc(1'b0, 1'b1, o);
                end
                6'h03: begin
                    o = '0; o.rw = 1'b1; o.rdst = 2'd2; o.m2r = 2'd2; o.pcw = 1'b1;
                    o.pcsrc = 2'd2; o.done = 1'b1;
                    push_cyc(1'b0, 1'b1, o);
                end
                default: ;
            endcase
        end
    endtask

    task automatic push_reset(input int n);
        m_first = 1'b0;
        m_lat = 0;
        for (int i = 0; i < n; i++) push_cyc(1'b1, 1'b0, '0);
    endtask

    // Compare process: every cycle, plus instruction latency on each instr_done pulse.
    always @(negedge clk) begin
        if (cur_valid) begin
            cyc_no++;
            if (cur.start) begin
                cyc_in = 1;
                lat_exp = cur.lat;
            end else begin
                cyc_in++;
            end
            n_cmp++;
            if (dut_o !== cur.exp) begin
                n_fail++;
                $display("FAIL outputs cyc%0d op=%h fn=%h rst=%b mr=%b: got %h want %h",
                         cyc_no, cur.op, cur.fn, cur.rst, cur.mr, dut_o, cur.exp);
            end
            if (instr_done === 1'b1) begin
                n_cmp++;
                if (cyc_in != lat_exp) begin
                    n_fail++;
                    $display("FAIL latency cyc%0d op=%h: got %0d cycles want %0d",
                             cyc_no, cur.op, cyc_in, lat_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int keep;
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        m_op = 6'h00;
        m_fn = 6'h00;

        push_reset(2);
        run_instr(6'h00, 6'h20, 0, 0, 4);   // add
        run_instr(6'h23, 6'h00, 0, 3, 8);   // lw, 3 wait cycles
        run_instr(6'h05, 6'h00, 0, 0, 3);   // bne
        run_instr(6'h04, 6'h00, 0, 0, 3);   // beq
        run_instr(6'h03, 6'h00, 0, 0, 3);   // jal
        run_instr(6'h00, 6'h08, 0, 0, 3);   // jr
        run_instr(6'h02, 6'h00, 0, 0, 3);   // j
        run_instr(6'h3F, 6'h00, 0, 0, 0);   // illegal
        run_instr(6'h08, 6'h00, 0, 0, 4);   // addi
        run_instr(6'h0C, 6'h00, 0, 0, 4);   // andi
        run_instr(6'h0D, 6'h00, 0, 0, 4);   // ori
        run_instr(6'h0F, 6'h00, 0, 0, 4);   // lui
        run_instr(6'h2B, 6'h00, 0, 0, 4);   // sw
        run_instr(6'h2B, 6'h00, 0, 2, 6);   // sw, 2 wait cycles
        run_instr(6'h23, 6'h00, 0, 0, 5);   // lw
        run_instr(6'h00, 6'h22, 2, 0, 6);   // sub, 2 fetch waits
        keep = q.size() + 5;                // fetch, decode, addr, two read waits
        run_instr(6'h23, 6'h00, 0, 5, 0);
        while (q.size() > keep) void'(q.pop_back());
        push_reset(1);
        run_instr(6'h0D, 6'h00, 1, 0, 5);   // ori right after abort
        run_instr(6'h00, 6'h20, 0, 0, 4);

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            reset = q[i].rst;
            mem_ready = q[i].mr;
            opcode = q[i].op;
            funct = q[i].fn;
            cur = q[i];
            cur_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
